// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder giving an external master auto-incrementing byte access
// to a small register file, with a local write port and an SPI-write event output.
module spi_slave_regs #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ncs_i,
    input  logic                 sclk_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    input  logic                 loc_wr_en_i,
    input  logic [ADDR_BITS-1:0] loc_addr_i,
    input  logic [7:0]           loc_wr_data_i,
    output logic                 wr_valid_o,
    output logic [ADDR_BITS-1:0] wr_addr_o,
    output logic [7:0]           wr_data_o,
    output logic                 busy_o,
    output logic [1:0]           dbg_state_o
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   ncs_s1_q, ncs_s2_q;
    logic                   sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic                   mosi_s1_q, mosi_s2_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             sh_q;
    logic [7:0]             tx_q;
    logic                   rw_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   miso_q;
    logic                   armed_q;
    logic [1:0]             settle_q;
    logic                   st_pend_q;
    logic [ADDR_BITS-1:0]   st_addr_q;
    logic [7:0]             st_data_q;
    logic                   wr_valid_q;
    logic [ADDR_BITS-1:0]   wr_addr_q;
    logic [7:0]             wr_data_q;
    logic [7:0]             regs_q [0:DEPTH-1];

    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [7:0]             byte_d;
    logic [ADDR_BITS-1:0]   cmd_addr_d;

    always_comb begin
        sclk_rise  = sclk_s2_q & ~sclk_s3_q;
        sclk_fall  = ~sclk_s2_q & sclk_s3_q;
        byte_d     = {sh_q[6:0], mosi_s2_q};
        cmd_addr_d = byte_d[ADDR_BITS-1:0];
    end

    // Decode FSM. A byte store is staged one cycle (st_pend_q) so the register
    // update and the wr_valid pulse land on the same clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ncs_s1_q   <= 1'b1;
            ncs_s2_q   <= 1'b1;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_s3_q  <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            bit_cnt_q  <= 3'd0;
            sh_q       <= 8'h00;
            tx_q       <= 8'h00;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            miso_q     <= 1'b1;
            armed_q    <= 1'b0;
            settle_q   <= 2'd2;
            st_pend_q  <= 1'b0;
            st_addr_q  <= '0;
            st_data_q  <= 8'h00;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            ncs_s1_q  <= ncs_i;
            ncs_s2_q  <= ncs_s1_q;
            sclk_s1_q <= sclk_i;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= mosi_i;
            mosi_s2_q <= mosi_s1_q;

            st_pend_q  <= 1'b0;
            wr_valid_q <= st_pend_q;
            if (st_pend_q) begin
                wr_addr_q <= st_addr_q;
                wr_data_q <= st_data_q;
            end

            if (settle_q != 2'd0) begin
                settle_q <= settle_q - 2'd1;
            end

            if (ncs_s2_q) begin
                // Arming waits until the synchroniser holds a real pin sample,
                // so a select held low across reset is not taken as a new frame.
                state_q   <= ST_IDLE;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b1;
                if (settle_q == 2'd0) begin
                    armed_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (armed_q) begin
                            state_q   <= ST_CMD;
                            armed_q   <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            miso_q    <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        miso_q <= 1'b0;
                        if (sclk_rise) begin
                            sh_q      <= byte_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= ST_DATA;
                                rw_q    <= byte_d[7];
                                if (byte_d[7]) begin
                                    tx_q   <= regs_q[cmd_addr_d];
                                    addr_q <= cmd_addr_d + ADDR_ONE;
                                end else begin
                                    tx_q   <= 8'h00;
                                    addr_q <= cmd_addr_d;
                                end
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            sh_q      <= byte_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                addr_q <= addr_q + ADDR_ONE;
                                if (rw_q) begin
                                    tx_q <= regs_q[addr_q];
                                end else begin
                                    st_pend_q <= 1'b1;
                                    st_addr_q <= addr_q;
                                    st_data_q <= byte_d;
                                end
                            end
                        end else if (sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // SPI store is applied after the local write so it wins on collision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (loc_wr_en_i) begin
                regs_q[loc_addr_i] <= loc_wr_data_i;
            end
            if (st_pend_q) begin
                regs_q[st_addr_q] <= st_data_q;
            end
        end
    end

    assign miso_o      = miso_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = ~ncs_s2_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: bit-level SPI master tasks, a wr_valid
// monitor feeding a capture queue, and per-scenario tasks with inline checks.
module tb_spi_slave_regs;

    localparam int AB = 4;

    logic          clk;
    logic          rst;
    logic          ncs;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          loc_wr_en;
    logic [AB-1:0] loc_addr;
    logic [7:0]    loc_wr_data;
    logic          wr_valid;
    logic [AB-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic [1:0]    dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_rise_cyc = 0;

    logic [AB+7:0] cap_q[$];
    int            lat_q[$];
    logic [AB+7:0] exp_q[$];

    spi_slave_regs #(.ADDR_BITS(AB)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ncs_i         (ncs),
        .sclk_i        (sclk),
        .mosi_i        (mosi),
        .miso_o        (miso),
        .loc_wr_en_i   (loc_wr_en),
        .loc_addr_i    (loc_addr),
        .loc_wr_data_i (loc_wr_data),
        .wr_valid_o    (wr_valid),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .busy_o        (busy),
        .dbg_state_o   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // wr_valid monitor
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            cap_q.push_back({wr_addr, wr_data});
            lat_q.push_back(cyc - last_rise_cyc);
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        tick(5);
        m = miso;
        last_rise_cyc = cyc;
        sclk = 1'b1;
        tick(5);
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic spi_start;
        ncs = 1'b0;
        tick(5);
    endtask

    task automatic spi_end;
        tick(5);
        ncs = 1'b1;
        mosi = 1'b0;
        tick(8);
    endtask

    task automatic clear_caps;
        cap_q.delete();
        lat_q.delete();
        exp_q.delete();
    endtask

    // Scenarios
    task automatic test_reset;
        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        loc_wr_en = 1'b0; loc_addr = '0; loc_wr_data = 8'h00;
        tick(3);
        tests_run++; if (miso !== 1'b1) begin tests_failed++; $display("FAIL reset_miso: got %b expected 1", miso); end
        tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        tests_run++; if (wr_addr !== 4'h0) begin tests_failed++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
        tests_run++; if (wr_data !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst = 1'b0;
        tick(6);
    endtask

    task automatic test_write;
        logic [7:0] r;
        clear_caps();
        exp_q.push_back({4'h2, 8'hA5});
        exp_q.push_back({4'h3, 8'h5A});
        spi_start();
        spi_xfer(8'h02, r);
        spi_xfer(8'hA5, r);
        spi_xfer(8'h5A, r);
        spi_end();
        tests_run++; if (cap_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL write_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            tests_run++; if (cap_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL write_event%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
            tests_run++; if (lat_q[i] != 4) begin tests_failed++; $display("FAIL write_latency%0d: got %0d expected 4", i, lat_q[i]); end
        end
        tests_run++; if (miso !== 1'b1) begin tests_failed++; $display("FAIL idle_miso: got %b expected 1", miso); end
    endtask

    task automatic test_read;
        logic [7:0] r0, r1, r2;
        clear_caps();
        spi_start();
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL read_busy: got %b expected 1", busy); end
        spi_xfer(8'h82, r0);
        spi_xfer(8'h00, r1);
        spi_xfer(8'hFF, r2);
        spi_end();
        tests_run++; if (r0 !== 8'h00) begin tests_failed++; $display("FAIL read_cmd_miso: got %h expected 00", r0); end
        tests_run++; if (r1 !== 8'hA5) begin tests_failed++; $display("FAIL read_byte0: got %h expected a5", r1); end
        tests_run++; if (r2 !== 8'h5A) begin tests_failed++; $display("FAIL read_byte1: got %h expected 5a", r2); end
        tests_run++; if (cap_q.size() != 0) begin tests_failed++; $display("FAIL read_no_wr_valid: got %0d expected 0", cap_q.size()); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL read_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_wrap;
        logic [7:0] r, r1, r2;
        clear_caps();
        exp_q.push_back({4'hF, 8'h11});
        exp_q.push_back({4'h0, 8'h22});
        spi_start();
        spi_xfer(8'h0F, r);
        spi_xfer(8'h11, r);
        spi_xfer(8'h22, r);
        spi_end();
        tests_run++; if (cap_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL wrap_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            tests_run++; if (cap_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL wrap_event%0d: got %h expected %h", i, cap_q[i], exp_q[i]); end
        end
        spi_start();
        spi_xfer(8'h8F, r);
        spi_xfer(8'h00, r1);
        spi_xfer(8'h00, r2);
        spi_end();
        tests_run++; if (r1 !== 8'h11) begin tests_failed++; $display("FAIL wrap_read15: got %h expected 11", r1); end
        tests_run++; if (r2 !== 8'h22) begin tests_failed++; $display("FAIL wrap_read0: got %h expected 22", r2); end
    endtask

    task automatic test_partial;
        logic [7:0] r, r1, r2;
        logic m;
        clear_caps();
        exp_q.push_back({4'h4, 8'hFF});
        spi_start();
        spi_xfer(8'h04, r);
        spi_xfer(8'hFF, r);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        spi_end();
        tests_run++; if (cap_q.size() != 1) begin tests_failed++; $display("FAIL partial_count: got %0d expected 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            tests_run++; if (cap_q[0] !== exp_q[0]) begin tests_failed++; $display("FAIL partial_event: got %h expected %h", cap_q[0], exp_q[0]); end
        end
        spi_start();
        spi_xfer(8'h84, r);
        spi_xfer(8'h00, r1);
        spi_xfer(8'h00, r2);
        spi_end();
        tests_run++; if (r1 !== 8'hFF) begin tests_failed++; $display("FAIL partial_reg4: got %h expected ff", r1); end
        tests_run++; if (r2 !== 8'h00) begin tests_failed++; $display("FAIL partial_reg5: got %h expected 00", r2); end
    endtask

    task automatic test_local;
        logic [7:0] r, r1;
        clear_caps();
        loc_wr_en = 1'b1; loc_addr = 4'h6; loc_wr_data = 8'h3C;
        tick(1);
        loc_wr_en = 1'b0;
        tick(3);
        tests_run++; if (cap_q.size() != 0) begin tests_failed++; $display("FAIL local_no_wr_valid: got %0d expected 0", cap_q.size()); end
        spi_start();
        spi_xfer(8'h86, r);
        spi_xfer(8'h00, r1);
        spi_end();
        tests_run++; if (r1 !== 8'h3C) begin tests_failed++; $display("FAIL local_read6: got %h expected 3c", r1); end
    endtask

    task automatic test_collision;
        logic [7:0] r, r1, d;
        logic m;
        clear_caps();
        d = 8'h99;
        spi_start();
        spi_xfer(8'h07, r);
        for (int i = 7; i >= 1; i--) spi_bit(d[i], m);
        // last bit by hand so the local write lands on the SPI store edge
        mosi = d[0];
        tick(5);
        last_rise_cyc = cyc;
        sclk = 1'b1;
        tick(3);
        loc_wr_en = 1'b1; loc_addr = 4'h7; loc_wr_data = 8'h77;
        tick(1);
        loc_wr_en = 1'b0;
        tick(1);
        sclk = 1'b0;
        spi_end();
        tests_run++; if (cap_q.size() != 1) begin tests_failed++; $display("FAIL collide_count: got %0d expected 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            tests_run++; if (cap_q[0] !== {4'h7, 8'h99}) begin tests_failed++; $display("FAIL collide_event: got %h expected 799", cap_q[0]); end
        end
        spi_start();
        spi_xfer(8'h87, r);
        spi_xfer(8'h00, r1);
        spi_end();
        tests_run++; if (r1 !== 8'h99) begin tests_failed++; $display("FAIL collide_reg7: got %h expected 99", r1); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] r, r1, r2;
        logic m;
        clear_caps();
        spi_start();
        spi_xfer(8'h08, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
        rst = 1'b1;
        tick(2);
        tests_run++; if (miso !== 1'b1) begin tests_failed++; $display("FAIL rstmid_miso: got %b expected 1", miso); end
        tests_run++; if (wr_valid !== 1'b0 || wr_addr !== 4'h0 || wr_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_wr: got %b/%h/%h expected 0/0/00", wr_valid, wr_addr, wr_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        rst = 1'b0;
        // select still low: block must ignore these bytes
        spi_xfer(8'h03, r);
        spi_xfer(8'h77, r);
        tests_run++; if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rstmid_idle: got %0d expected 0", dbg_state); end
        spi_end();
        tests_run++; if (cap_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_no_write: got %0d expected 0", cap_q.size()); end
        spi_start();
        spi_xfer(8'h82, r);
        spi_xfer(8'h00, r1);
        spi_xfer(8'h00, r2);
        spi_end();
        tests_run++; if (r1 !== 8'h00 || r2 !== 8'h00) begin tests_failed++; $display("FAIL rstmid_cleared: got %h %h expected 00 00", r1, r2); end
        spi_start();
        spi_xfer(8'h0A, r);
        spi_xfer(8'h42, r);
        spi_end();
        tests_run++; if (cap_q.size() != 1) begin tests_failed++; $display("FAIL rstmid_new_count: got %0d expected 1", cap_q.size()); end
        if (cap_q.size() > 0) begin
            tests_run++; if (cap_q[0] !== {4'hA, 8'h42}) begin tests_failed++; $display("FAIL rstmid_new_event: got %h expected a42", cap_q[0]); end
        end
        spi_start();
        spi_xfer(8'h8A, r);
        spi_xfer(8'h00, r1);
        spi_end();
        tests_run++; if (r1 !== 8'h42) begin tests_failed++; $display("FAIL rstmid_readback: got %h expected 42", r1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_partial();
        test_local();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
